// File: rtl/clk_div_ctrl_pkg.sv
// rtl/clk_div_ctrl_pkg.sv - state type, divide limits and waveform helper shared by clk_div_ctrl
package clk_div_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2,
    STOP = 2'd3
  } clk_div_state_e;

  localparam int unsigned DIV_MIN = 2;

  // Cycles spent high per period; odd N leaves the spare cycle in the low phase.
  function automatic int unsigned clk_div_high_len(input int unsigned n);
    return n >> 1;
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// rtl/clk_div_core.sv - divide counter, low/high phase compare and terminal-count strobe
module clk_div_core
  import clk_div_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk_in,
  input  logic             rst_,
  input  logic             run,
  input  logic [DIV_W-1:0] div_cur,
  input  logic [DIV_W-1:0] div_upd,
  output logic             tc,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_nxt;
  logic [DIV_W-1:0] hi_len;
  logic [DIV_W-1:0] lo_len;
  logic [DIV_W-1:0] last_idx;

  assign tc = run && (cnt == div_cur - ONE);

  always_comb begin
    cnt_nxt = '0;
    if (run && !tc) begin
      cnt_nxt = cnt + ONE;
    end
  end

  // Decode against the divide in force after the edge so the registered
  // outputs stay aligned with cnt, including across a factor change at TC.
  always_comb begin
    hi_len   = DIV_W'(clk_div_high_len(32'(div_upd)));
    lo_len   = div_upd - hi_len;
    last_idx = div_upd - ONE;
  end

  always_ff @(posedge clk_in or negedge rst_) begin
    if (!rst_) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      clk_out <= (cnt_nxt >= lo_len);
      tick    <= (cnt_nxt == last_idx);
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - runtime-programmable clock divider with period-aligned start/stop/reconfigure
// Optional CLK_DIV_CTRL_CHK_EN: reject cfg_div below DIV_MIN with cfg_err instead of clamping.
module clk_div_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned DIV_RST = 16
) (
  input  logic             clk_in,
  input  logic             rst_,
  input  logic             en,
  input  logic             cfg_req,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ack,
  output logic             clk_out,
  output logic             tick,
  output logic             busy
`ifdef CLK_DIV_CTRL_CHK_EN
  ,
  output logic             cfg_err
`endif
);

  localparam logic [DIV_W-1:0] DIV_RST_V = DIV_W'(DIV_RST);
  localparam logic [DIV_W-1:0] DIV_MIN_V = DIV_W'(DIV_MIN);

  clk_div_state_e   state;
  clk_div_state_e   state_nxt;
  logic [DIV_W-1:0] div_cur;
  logic [DIV_W-1:0] div_cur_d;
  logic [DIV_W-1:0] div_nxt;
  logic [DIV_W-1:0] div_nxt_d;
  logic             ack_d;
  logic             tc;
  logic             run;
  logic             req_live;
  logic             req_bad;
  logic             req_take;
  logic [DIV_W-1:0] req_div;

  // A request still held during its own ack cycle must not be taken twice.
  assign req_live = cfg_req && !cfg_ack;

`ifdef CLK_DIV_CTRL_CHK_EN
  assign req_bad = req_live && (cfg_div < DIV_MIN_V);
  assign req_div = cfg_div;
`else
  assign req_bad = 1'b0;
  assign req_div = (cfg_div < DIV_MIN_V) ? DIV_MIN_V : cfg_div;
`endif

  assign req_take = req_live && !req_bad;
  assign run      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    div_cur_d = div_cur;
    div_nxt_d = div_nxt;
    ack_d     = req_bad;
    case (state)
      IDLE: begin
        if (req_take) begin
          div_cur_d = req_div;
          div_nxt_d = req_div;
          ack_d     = 1'b1;
        end
        if (en) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (req_take) begin
          div_nxt_d = req_div;
          state_nxt = PEND;
        end else if (!en) begin
          state_nxt = STOP;
        end
      end
      PEND: begin
        if (tc) begin
          div_cur_d = div_nxt;
          ack_d     = 1'b1;
          state_nxt = en ? RUN : IDLE;
        end
      end
      STOP: begin
        if (en) begin
          state_nxt = RUN;
        end else if (tc) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_) begin
    if (!rst_) begin
      state   <= IDLE;
      div_cur <= DIV_RST_V;
      div_nxt <= DIV_RST_V;
      cfg_ack <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_cur <= div_cur_d;
      div_nxt <= div_nxt_d;
      cfg_ack <= ack_d;
      busy    <= (state_nxt != IDLE);
    end
  end

`ifdef CLK_DIV_CTRL_CHK_EN
  always_ff @(posedge clk_in or negedge rst_) begin
    if (!rst_) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= req_bad;
    end
  end
`endif

  clk_div_core #(
    .DIV_W (DIV_W)
  ) u_core (
    .clk_in  (clk_in),
    .rst_    (rst_),
    .run     (run),
    .div_cur (div_cur),
    .div_upd (div_cur_d),
    .tc      (tc),
    .clk_out (clk_out),
    .tick    (tick)
  );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - self-checking bench for clk_div_ctrl (table, directed sequences, random vs model)
module tb_clk_div_ctrl;

  localparam int DIV_W = 8;

  logic             clk_in  = 1'b0;
  logic             rst_    = 1'b0;
  logic             en      = 1'b0;
  logic             cfg_req = 1'b0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic             cfg_ack;
  logic             clk_out;
  logic             tick;
  logic             busy;
  logic             cfg_err;

  int n_checks = 0;
  int n_fail   = 0;
  bit mdl_chk  = 1'b0;

  always #5 clk_in = ~clk_in;

  clk_div_ctrl #(
    .DIV_W   (DIV_W),
    .DIV_RST (16)
  ) dut (
    .clk_in  (clk_in),
    .rst_    (rst_),
    .en      (en),
    .cfg_req (cfg_req),
    .cfg_div (cfg_div),
    .cfg_ack (cfg_ack),
    .clk_out (clk_out),
    .tick    (tick),
    .busy    (busy)
`ifdef CLK_DIV_CTRL_CHK_EN
    ,
    .cfg_err (cfg_err)
`endif
  );

`ifndef CLK_DIV_CTRL_CHK_EN
  assign cfg_err = 1'b0;
`endif

  // Behavioural reference: position within the period plus mode flags.
  typedef struct {
    bit active;
    bit pending;
    bit stopping;
    bit ack;
    bit err;
    int pos;
    int n_cur;
    int n_new;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.active = 0; r.pending = 0; r.stopping = 0; r.ack = 0; r.err = 0;
    r.pos = 0; r.n_cur = 16; r.n_new = 16;
    return r;
  endfunction

  function automatic model_t model_step(input model_t s, input logic en_i,
                                        input logic req_i, input logic [DIV_W-1:0] div_i);
    model_t r;
    bit last;
    bit take;
    int d;
    r    = s;
    last = s.active && (s.pos == s.n_cur - 1);
    take = req_i && !s.ack;
    d    = (int'(div_i) < 2) ? 2 : int'(div_i);
    r.ack = 0;
    r.err = 0;
`ifdef CLK_DIV_CTRL_CHK_EN
    if (take && int'(div_i) < 2) begin
      r.ack = 1; r.err = 1; take = 0;
    end
`endif
    if (!s.active) begin
      if (take) begin r.n_cur = d; r.ack = 1; end
      if (en_i) r.active = 1;
    end else begin
      r.pos = last ? 0 : s.pos + 1;
      if (s.pending) begin
        if (last) begin
          r.n_cur = s.n_new; r.ack = 1; r.pending = 0; r.active = en_i;
        end
      end else if (s.stopping) begin
        if (en_i) r.stopping = 0;
        else if (last) begin r.active = 0; r.stopping = 0; end
      end else if (take) begin
        r.n_new = d; r.pending = 1;
      end else if (!en_i) begin
        r.stopping = 1;
      end
    end
    if (!r.active) r.pos = 0;
    return r;
  endfunction

  function automatic logic [4:0] exp_outs(input model_t s);
    logic c;
    logic t;
    c = (s.pos >= s.n_cur - s.n_cur / 2);
    t = s.active && (s.pos == s.n_cur - 1);
    return {c, t, s.active ? 1'b1 : 1'b0, s.ack ? 1'b1 : 1'b0, s.err ? 1'b1 : 1'b0};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk_in or negedge rst_) begin
    if (!rst_) m <= model_reset();
    else       m <= model_step(m, en, cfg_req, cfg_div);
  end

  always @(negedge clk_in) begin
    if (mdl_chk)
      check("model_outputs{clk,tick,busy,ack,err}",
            int'({clk_out, tick, busy, cfg_ack, cfg_err}), int'(exp_outs(m)));
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic cfg_idle(input logic [DIV_W-1:0] d, input bit exp_err, input string name);
    cfg_req = 1'b1;
    cfg_div = d;
    step();
    check({name, "_ack"}, int'(cfg_ack), 1);
    check({name, "_err"}, int'(cfg_err), int'(exp_err));
    check({name, "_idle"}, int'(busy), 0);
    cfg_req = 1'b0;
  endtask

  // Called in the cycle where cnt=0; checks two whole periods.
  task automatic measure(input int low, input int high, input string name);
    int n;
    int bad;
    n   = low + high;
    bad = 0;
    for (int i = 0; i < 2 * n; i++) begin
      if (clk_out !== ((i % n) >= low)) bad++;
      if (tick !== ((i % n) == n - 1)) bad++;
      if (busy !== 1'b1) bad++;
      step();
    end
    check(name, bad, 0);
  endtask

  task automatic stop_run(input string name);
    int cyc;
    cyc = 0;
    en  = 1'b0;
    while (busy && cyc < 300) begin
      step();
      cyc++;
    end
    check({name, "_busy_fell"}, int'(busy), 0);
    check({name, "_clk_low"}, int'(clk_out), 0);
  endtask

  task automatic wait_ack(input int limit, output int cyc);
    cyc = 0;
    while (!cfg_ack && cyc < limit) begin
      step();
      cyc++;
    end
  endtask

  typedef struct {
    logic [DIV_W-1:0] div;
    int               low;
    int               high;
    bit               err;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int cyc;
    int bad;
    tbl[0] = '{8'd7, 4, 3, 1'b0};
    tbl[1] = '{8'd5, 3, 2, 1'b0};
`ifdef CLK_DIV_CTRL_CHK_EN
    tbl[2] = '{8'd1, 3, 2, 1'b1};
`else
    tbl[2] = '{8'd1, 1, 1, 1'b0};
`endif
    tbl[3] = '{8'd2, 1, 1, 1'b0};
    tbl[4] = '{8'd9, 5, 4, 1'b0};
`ifdef CLK_DIV_CTRL_CHK_EN
    tbl[5] = '{8'd0, 5, 4, 1'b1};
`else
    tbl[5] = '{8'd0, 1, 1, 1'b0};
`endif

    repeat (3) @(posedge clk_in);
    #1;
    check("rst_clk_out", int'(clk_out), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cfg_ack", int'(cfg_ack), 0);
    check("rst_cfg_err", int'(cfg_err), 0);
    rst_    = 1'b1;
    mdl_chk = 1'b1;

    // Default N=16: 8 low, 8 high, tick every 16.
    en = 1'b1;
    step();
    check("start_busy", int'(busy), 1);
    measure(8, 8, "n16_wave");

    // Request 5 while cnt=3; ack lands on the TC edge 12 edges after sampling.
    repeat (3) step();
    cfg_req = 1'b1;
    cfg_div = 8'd5;
    wait_ack(40, cyc);
    check("run_ack_latency", cyc, 13);
    cfg_req = 1'b0;
    measure(3, 2, "n5_after_run_cfg");
    stop_run("stop_n5");

    for (int k = 0; k < 6; k++) begin
      cfg_idle(tbl[k].div, tbl[k].err, $sformatf("tbl%0d", k));
      en = 1'b1;
      step();
      measure(tbl[k].low, tbl[k].high, $sformatf("tbl%0d_wave", k));
      stop_run($sformatf("tbl%0d_stop", k));
    end

    // N=6: drop en at cnt=1, re-assert at cnt=4, waveform must not break.
    cfg_idle(8'd6, 1'b0, "n6");
    en  = 1'b1;
    step();
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      if (clk_out !== ((i % 6) >= 3)) bad++;
      if (tick !== ((i % 6) == 5)) bad++;
      if (busy !== 1'b1) bad++;
      if (i == 1) en = 1'b0;
      if (i == 4) en = 1'b1;
      step();
    end
    check("n6_reassert_seamless", bad, 0);

    // Drop en at cnt=1 for good: finish the period, then idle low.
    step();
    en  = 1'b0;
    bad = 0;
    for (int i = 1; i < 6; i++) begin
      if (busy !== 1'b1) bad++;
      if (tick !== (i == 5)) bad++;
      if (clk_out !== (i >= 3)) bad++;
      step();
    end
    check("n6_stop_tail", bad, 0);
    check("n6_stop_busy", int'(busy), 0);
    check("n6_stop_clk", int'(clk_out), 0);
    check("n6_stop_tick", int'(tick), 0);

    // Reset while a request is pending: everything clears, no ack, N back to 16.
    cfg_idle(8'd16, 1'b0, "n16_set");
    en = 1'b1;
    step();
    repeat (2) step();
    cfg_req = 1'b1;
    cfg_div = 8'd5;
    repeat (8) step();
    check("pend_pre_clk_high", int'(clk_out), 1);
    #3;
    rst_ = 1'b0;
    #1;
    check("pend_rst_clk_out", int'(clk_out), 0);
    check("pend_rst_busy", int'(busy), 0);
    check("pend_rst_tick", int'(tick), 0);
    check("pend_rst_ack", int'(cfg_ack), 0);
    cfg_req = 1'b0;
    en      = 1'b0;
    step();
    rst_ = 1'b1;
    bad  = 0;
    for (int i = 0; i < 20; i++) begin
      if (cfg_ack !== 1'b0) bad++;
      step();
    end
    check("pend_rst_no_ack", bad, 0);
    en = 1'b1;
    step();
    measure(8, 8, "n16_after_reset");
    stop_run("stop_after_reset");

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if (cfg_req && cfg_ack) begin
        cfg_req = 1'b0;
      end else if (!cfg_req && $urandom_range(0, 11) == 0) begin
        cfg_div = 8'($urandom_range(0, 12));
        cfg_req = 1'b1;
      end
      if ($urandom_range(0, 23) == 0) en = ~en;
      rst_ = (i == 1500) ? 1'b0 : 1'b1;
      step();
    end

    mdl_chk = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, actual timeout, required finish");
    $fatal(1);
  end

endmodule
